unidade_controle_genius_param: RTL and testbench
================================================

Name: unidade_controle_genius_param

Overview:
Parametrised next-generation control unit for the memory-game datapath. It absorbs the sequence counter (S), the address counter (E), the LED show on/off timers and the play timeout into one block. It adds a selectable sequence length (level), multiple lives with replay after an error, and a distinct timeout indication. It sits between the game datapath (sequence memory, play register, comparator) and the top-level I/O.

Parameters:
ADDR_W, 4, width of memory address, sequence and address counters (max sequence length 2^ADDR_W)
LED_ON_CYCLES, 500, clock cycles the LEDs are lit per shown item (>=1)
LED_OFF_CYCLES, 250, clock cycles the LEDs are dark between shown items (>=1)
TIMEOUT_CYCLES, 5000, clock cycles allowed per play before timeout (>=2)
MAX_LIVES, 3, errors tolerated before game over (1..7)

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  reset, synchronous active-low
iniciar  in  1  start/restart request, level-sensitive, sampled in INICIAL/FIM states
nivel  in  1  0 = short game (2^(ADDR_W-1) items), 1 = full game (2^ADDR_W items); latched in PREPARA
tem_jogada  in  1  one-cycle pulse: a valid play is present on the datapath
jogada_igual  in  1  comparator result, valid in COMPARA
endereco  out  ADDR_W  memory address (counter E)
sequencia  out  ADDR_W  current last index of round (counter S)
zeraR  out  1  clear play register
registraR  out  1  load play register
leds_acesos  out  1  high while memory item is shown
estado_espera  out  1  high in ESPERA
vidas  out  3  lives remaining
acertou  out  1  high in FIM_ACERTO
errou  out  1  high in FIM_ERRO
errou_timeout  out  1  sticky: last life-loss was a timeout; cleared in PREPARA
pronto  out  1  high in either FIM state
db_estado  out  5  current state code

Behaviour:
- One clock; reset is synchronous and active-low: reset_n=0 at a rising edge -> INICIAL, E=S=0, vidas=MAX_LIVES, timer=0, nivel latch=0, errou_timeout=0; all Moore outputs as for INICIAL (zeraR=1, others 0). Reset overrides every other input in any state.
- Moore machine; one shared timer, cleared on every state change, increments while the state holds.
- States/codes: INICIAL 00, PREPARA 01, MOSTRA_ON 02, MOSTRA_OFF 03, PROX_LED 04, ZERA_END 05, ESPERA 06, REGISTRA 07, COMPARA 08, PROX_JOGADA 09, PROX_SEQ 0A, PERDE_VIDA 0B, FIM_ACERTO 0C, FIM_ERRO 0D. Unused codes -> INICIAL.
- INICIAL: iniciar -> PREPARA.
- PREPARA: E=S=0, vidas=MAX_LIVES, zeraR=1, latch nivel, clear errou_timeout -> MOSTRA_ON.
- MOSTRA_ON: leds_acesos=1 for exactly LED_ON_CYCLES cycles -> MOSTRA_OFF.
- MOSTRA_OFF: exactly LED_OFF_CYCLES cycles -> ZERA_END if E==S, else PROX_LED.
- PROX_LED: E+=1 -> MOSTRA_ON. ZERA_END: E=0 -> ESPERA.
- ESPERA: tem_jogada -> REGISTRA; else timer==TIMEOUT_CYCLES-1 -> PERDE_VIDA with errou_timeout=1. tem_jogada wins on the timeout cycle.
- REGISTRA: registraR=1 (1 cycle) -> COMPARA.
- COMPARA: !jogada_igual -> PERDE_VIDA (errou_timeout=0); E!=S -> PROX_JOGADA; E==S and S==LAST -> FIM_ACERTO; else PROX_SEQ.
- LAST = 2^ADDR_W-1 if latched nivel=1, else 2^(ADDR_W-1)-1.
- PROX_JOGADA: E+=1 -> ESPERA (timer restarts per play).
- PROX_SEQ: S+=1, E=0 -> MOSTRA_ON.
- PERDE_VIDA: vidas-=1. If the new vidas is 0 -> FIM_ERRO. Else E=0, S unchanged -> MOSTRA_ON (round replayed).
- FIM_ACERTO / FIM_ERRO: hold outputs; iniciar -> PREPARA.
- Counters never wrap during play: S stops at LAST, E at S. vidas is never decremented below 0.
- iniciar is ignored outside INICIAL and the FIM states.

Test Plan (ADDR_W=2, LED_ON=3, LED_OFF=2, TIMEOUT=10, MAX_LIVES=2):
1. reset_n=0 for 2 cycles mid-ESPERA -> db_estado=00, endereco=0, sequencia=0, vidas=2, zeraR=1, all flags 0.
2. iniciar, nivel=0, round 0 -> leds_acesos high for exactly 3 cycles, low 2, then ESPERA with endereco=0. Correct plays through S=1 -> FIM_ACERTO, acertou=1, pronto=1, sequencia=1.
3. nivel=1, all plays correct -> 4 rounds shown with 1,2,3,4 LED flashes; FIM_ACERTO with sequencia=3.
4. In round S=1, wrong second play -> vidas=1, errou_timeout=0, replay shows 2 flashes, sequencia stays 1. Second wrong play -> FIM_ERRO, vidas=0, errou=1.
5. No play for 10 cycles in ESPERA -> PERDE_VIDA, errou_timeout=1. tem_jogada on exactly the 10th cycle -> REGISTRA, no life lost.
6. In FIM_ERRO, assert iniciar -> PREPARA next cycle; vidas=2, errou_timeout=0, sequencia=0.

Source files
------------

// File: rtl/unidade_controle_genius_param.sv
// -----------------------------------------------------------------------------
// unidade_controle_genius_param
//
// Control unit for the memory-game datapath. A single block holds the sequence
// counter (S), the address counter (E), the LED show timers, the per-play
// timeout and the lives counter. Game length is selectable (short/full),
// several lives are available (an error replays the current round), and a
// timeout is reported separately from a wrong play.
//
// Ports
//   clock          system clock, all state on rising edge
//   reset_n        synchronous active-low reset
//   iniciar        start/restart request, honoured in INICIAL and FIM states
//   nivel          0 = short game (2^(ADDR_W-1) items), 1 = full (2^ADDR_W)
//   tem_jogada     one-cycle pulse: a valid play is on the datapath
//   jogada_igual   comparator result, valid in COMPARA
//   endereco       memory address (counter E)
//   sequencia      last index of the current round (counter S)
//   zeraR          clear play register
//   registraR      load play register
//   leds_acesos    high while a memory item is shown
//   estado_espera  high while waiting for a play
//   vidas          lives remaining
//   acertou        game won
//   errou          game lost
//   errou_timeout  sticky: last life lost was a timeout
//   pronto         game over (won or lost)
//   db_estado      current state code
//
// State table
//   state        | code | meaning
//   INICIAL      | 00   | idle after reset, waiting for iniciar
//   PREPARA      | 01   | clear counters, restore lives, latch level
//   MOSTRA_ON    | 02   | item E lit for LED_ON_CYCLES
//   MOSTRA_OFF   | 03   | dark gap for LED_OFF_CYCLES
//   PROX_LED     | 04   | advance E to next item to show
//   ZERA_END     | 05   | rewind E before the player repeats the round
//   ESPERA       | 06   | waiting for a play, timeout running
//   REGISTRA     | 07   | load the play register
//   COMPARA      | 08   | evaluate comparator result
//   PROX_JOGADA  | 09   | advance E to next expected play
//   PROX_SEQ     | 0A   | round complete, extend sequence
//   PERDE_VIDA   | 0B   | life lost (wrong play or timeout)
//   FIM_ACERTO   | 0C   | game won
//   FIM_ERRO     | 0D   | no lives left
// -----------------------------------------------------------------------------
module unidade_controle_genius_param #(
    parameter int ADDR_W         = 4,
    parameter int LED_ON_CYCLES  = 500,
    parameter int LED_OFF_CYCLES = 250,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int MAX_LIVES      = 3
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              iniciar,
    input  logic              nivel,
    input  logic              tem_jogada,
    input  logic              jogada_igual,
    output logic [ADDR_W-1:0] endereco,
    output logic [ADDR_W-1:0] sequencia,
    output logic              zeraR,
    output logic              registraR,
    output logic              leds_acesos,
    output logic              estado_espera,
    output logic [2:0]        vidas,
    output logic              acertou,
    output logic              errou,
    output logic              errou_timeout,
    output logic              pronto,
    output logic [4:0]        db_estado
);

    localparam int MAX_ON_OFF = (LED_ON_CYCLES > LED_OFF_CYCLES) ? LED_ON_CYCLES : LED_OFF_CYCLES;
    localparam int MAX_CNT    = (MAX_ON_OFF > TIMEOUT_CYCLES) ? MAX_ON_OFF : TIMEOUT_CYCLES;
    localparam int TMR_W      = $clog2(MAX_CNT + 1);

    localparam logic [TMR_W-1:0]  TC_ON      = TMR_W'(LED_ON_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TC_OFF     = TMR_W'(LED_OFF_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TC_TIMEOUT = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMR_W-1:0]  TMR_SAT    = TMR_W'(MAX_CNT);
    localparam logic [ADDR_W-1:0] LAST_FULL  = '1;
    localparam logic [ADDR_W-1:0] LAST_SHORT = ADDR_W'((1 << (ADDR_W - 1)) - 1);
    localparam logic [2:0]        VIDAS_INI  = 3'(MAX_LIVES);

    typedef enum logic [4:0] {
        INICIAL     = 5'h00,
        PREPARA     = 5'h01,
        MOSTRA_ON   = 5'h02,
        MOSTRA_OFF  = 5'h03,
        PROX_LED    = 5'h04,
        ZERA_END    = 5'h05,
        ESPERA      = 5'h06,
        REGISTRA    = 5'h07,
        COMPARA     = 5'h08,
        PROX_JOGADA = 5'h09,
        PROX_SEQ    = 5'h0A,
        PERDE_VIDA  = 5'h0B,
        FIM_ACERTO  = 5'h0C,
        FIM_ERRO    = 5'h0D
    } estado_t;

    estado_t           r_estado;
    estado_t           w_prox;
    logic [TMR_W-1:0]  r_timer;
    logic [ADDR_W-1:0] r_end;
    logic [ADDR_W-1:0] r_seq;
    logic [2:0]        r_vidas;
    logic              r_nivel;
    logic              r_errou_timeout;

    logic [ADDR_W-1:0] w_last;
    logic              w_end_fim;
    logic              w_muda;

    assign w_last    = r_nivel ? LAST_FULL : LAST_SHORT;
    assign w_end_fim = (r_end == r_seq);
    assign w_muda    = (w_prox != r_estado);

    // -------------------------------------------------------------------------
    // State, timer and counters.
    // Counter updates are applied on entry to the state that owns them, so the
    // new value is already visible while that state is displayed.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_estado        <= INICIAL;
            r_timer         <= '0;
            r_end           <= '0;
            r_seq           <= '0;
            r_vidas         <= VIDAS_INI;
            r_nivel         <= 1'b0;
            r_errou_timeout <= 1'b0;
        end else begin
            r_estado <= w_prox;

            if (w_muda) begin
                r_timer <= '0;
            end else if (r_timer != TMR_SAT) begin
                r_timer <= r_timer + TMR_W'(1);
            end

            if (r_estado == PREPARA) begin
                r_nivel <= nivel;
            end

            if (w_muda) begin
                case (w_prox)
                    PREPARA: begin
                        r_end           <= '0;
                        r_seq           <= '0;
                        r_vidas         <= VIDAS_INI;
                        r_errou_timeout <= 1'b0;
                    end
                    PROX_LED, PROX_JOGADA: begin
                        if (!w_end_fim) begin
                            r_end <= r_end + ADDR_W'(1);
                        end
                    end
                    ZERA_END: begin
                        r_end <= '0;
                    end
                    PROX_SEQ: begin
                        r_end <= '0;
                        if (r_seq != w_last) begin
                            r_seq <= r_seq + ADDR_W'(1);
                        end
                    end
                    PERDE_VIDA: begin
                        if (r_vidas != 3'd0) begin
                            r_vidas <= r_vidas - 3'd1;
                        end
                        // Only the ESPERA exit is a timeout; COMPARA exit is a wrong play.
                        r_errou_timeout <= (r_estado == ESPERA);
                    end
                    MOSTRA_ON: begin
                        // Replay of the round after a lost life starts from item 0.
                        if (r_estado == PERDE_VIDA) begin
                            r_end <= '0;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next state and Moore outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        w_prox        = r_estado;
        zeraR         = 1'b0;
        registraR     = 1'b0;
        leds_acesos   = 1'b0;
        estado_espera = 1'b0;
        acertou       = 1'b0;
        errou         = 1'b0;
        pronto        = 1'b0;

        case (r_estado)
            INICIAL: begin
                zeraR = 1'b1;
                if (iniciar) begin
                    w_prox = PREPARA;
                end
            end
            PREPARA: begin
                zeraR  = 1'b1;
                w_prox = MOSTRA_ON;
            end
            MOSTRA_ON: begin
                leds_acesos = 1'b1;
                if (r_timer == TC_ON) begin
                    w_prox = MOSTRA_OFF;
                end
            end
            MOSTRA_OFF: begin
                if (r_timer == TC_OFF) begin
                    w_prox = w_end_fim ? ZERA_END : PROX_LED;
                end
            end
            PROX_LED: begin
                w_prox = MOSTRA_ON;
            end
            ZERA_END: begin
                w_prox = ESPERA;
            end
            ESPERA: begin
                estado_espera = 1'b1;
                // A play arriving on the last allowed cycle still counts.
                if (tem_jogada) begin
                    w_prox = REGISTRA;
                end else if (r_timer == TC_TIMEOUT) begin
                    w_prox = PERDE_VIDA;
                end
            end
            REGISTRA: begin
                registraR = 1'b1;
                w_prox    = COMPARA;
            end
            COMPARA: begin
                if (!jogada_igual) begin
                    w_prox = PERDE_VIDA;
                end else if (!w_end_fim) begin
                    w_prox = PROX_JOGADA;
                end else if (r_seq == w_last) begin
                    w_prox = FIM_ACERTO;
                end else begin
                    w_prox = PROX_SEQ;
                end
            end
            PROX_JOGADA: begin
                w_prox = ESPERA;
            end
            PROX_SEQ: begin
                w_prox = MOSTRA_ON;
            end
            PERDE_VIDA: begin
                // r_vidas was already decremented on entry.
                w_prox = (r_vidas == 3'd0) ? FIM_ERRO : MOSTRA_ON;
            end
            FIM_ACERTO: begin
                acertou = 1'b1;
                pronto  = 1'b1;
                if (iniciar) begin
                    w_prox = PREPARA;
                end
            end
            FIM_ERRO: begin
                errou  = 1'b1;
                pronto = 1'b1;
                if (iniciar) begin
                    w_prox = PREPARA;
                end
            end
            default: begin
                w_prox = INICIAL;
            end
        endcase
    end

    assign endereco      = r_end;
    assign sequencia     = r_seq;
    assign vidas         = r_vidas;
    assign errou_timeout = r_errou_timeout;
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_unidade_controle_genius_param.sv
module tb_unidade_controle_genius_param;

    localparam int AW   = 2;
    localparam int LON  = 3;
    localparam int LOFF = 2;
    localparam int TO   = 10;
    localparam int ML   = 2;

    localparam logic [31:0] C_INICIAL     = 32'h00;
    localparam logic [31:0] C_PREPARA     = 32'h01;
    localparam logic [31:0] C_ESPERA      = 32'h06;
    localparam logic [31:0] C_REGISTRA    = 32'h07;
    localparam logic [31:0] C_COMPARA     = 32'h08;
    localparam logic [31:0] C_PROX_JOGADA = 32'h09;
    localparam logic [31:0] C_PROX_SEQ    = 32'h0A;
    localparam logic [31:0] C_PERDE_VIDA  = 32'h0B;
    localparam logic [31:0] C_FIM_ACERTO  = 32'h0C;
    localparam logic [31:0] C_FIM_ERRO    = 32'h0D;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          iniciar;
    logic          nivel;
    logic          tem_jogada;
    logic          jogada_igual;
    logic [AW-1:0] endereco;
    logic [AW-1:0] sequencia;
    logic          zeraR;
    logic          registraR;
    logic          leds_acesos;
    logic          estado_espera;
    logic [2:0]    vidas;
    logic          acertou;
    logic          errou;
    logic          errou_timeout;
    logic          pronto;
    logic [4:0]    db_estado;

    unidade_controle_genius_param #(
        .ADDR_W(AW), .LED_ON_CYCLES(LON), .LED_OFF_CYCLES(LOFF),
        .TIMEOUT_CYCLES(TO), .MAX_LIVES(ML)
    ) dut (
        .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .nivel(nivel),
        .tem_jogada(tem_jogada), .jogada_igual(jogada_igual),
        .endereco(endereco), .sequencia(sequencia), .zeraR(zeraR),
        .registraR(registraR), .leds_acesos(leds_acesos),
        .estado_espera(estado_espera), .vidas(vidas), .acertou(acertou),
        .errou(errou), .errou_timeout(errou_timeout), .pronto(pronto),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;

    // Game-level reference model
    int m_s, m_e, m_vidas, m_last, m_phase;   // phase: 0 show, 1 waiting play, 2 game over
    bit m_to;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_estado"}, 32'(db_estado), C_INICIAL);
        chk({tag, "_endereco"}, 32'(endereco), 0);
        chk({tag, "_sequencia"}, 32'(sequencia), 0);
        chk({tag, "_vidas"}, 32'(vidas), ML);
        chk({tag, "_zeraR"}, 32'(zeraR), 1);
        chk({tag, "_flags"}, 32'({registraR, leds_acesos, estado_espera, acertou,
                                  errou, errou_timeout, pronto}), 0);
    endtask

    // Called on a negedge in INICIAL or a FIM state; ends on the PREPARA negedge.
    task automatic start_game(input bit lvl);
        iniciar = 1'b1;
        nivel   = lvl;
        @(negedge clock);
        iniciar = 1'b0;
        chk("prep_estado", 32'(db_estado), C_PREPARA);
        chk("prep_vidas", 32'(vidas), ML);
        chk("prep_timeout_flag", 32'(errou_timeout), 0);
        chk("prep_sequencia", 32'(sequencia), 0);
        chk("prep_zeraR", 32'(zeraR), 1);
        m_s     = 0;
        m_e     = 0;
        m_vidas = ML;
        m_to    = 1'b0;
        m_last  = lvl ? (1 << AW) - 1 : (1 << (AW - 1)) - 1;
        m_phase = 0;
    endtask

    // Called on the negedge just before the first MOSTRA_ON; ends on the
    // first ESPERA negedge. Each shown item costs ON + OFF + one step cycle.
    task automatic wait_show(input int n);
        int  cyc     = 0;
        int  on      = 0;
        int  flashes = 0;
        bit  prev    = 1'b0;
        bit  seen    = 1'b0;
        while (!seen && cyc < 400) begin
            @(negedge clock);
            if (estado_espera) begin
                seen = 1'b1;
            end else begin
                cyc++;
                if (leds_acesos) begin
                    on++;
                    if (!prev) flashes++;
                end
                prev = leds_acesos;
            end
        end
        chk("show_reached_espera", 32'(estado_espera), 1);
        chk("show_flashes", flashes, n);
        chk("show_led_on_cycles", on, LON * n);
        chk("show_length", cyc, (LON + LOFF + 1) * n);
        chk("show_endereco", 32'(endereco), 0);
        chk("show_sequencia", 32'(sequencia), m_s);
        m_phase = 1;
    endtask

    // Called on an ESPERA negedge with the timer at 0.
    task automatic do_play(input int k, input bit igual, input bit tmo, input bit noise);
        if (tmo) begin
            for (int i = 0; i < TO - 1; i++) begin
                @(negedge clock);
                if (noise) iniciar = 1'($urandom_range(0, 1));
            end
            iniciar = 1'b0;
            chk("espera_last_cycle", 32'(db_estado), C_ESPERA);
            @(negedge clock);
            m_vidas--;
            m_to = 1'b1;
            chk("timeout_estado", 32'(db_estado), C_PERDE_VIDA);
        end else begin
            for (int i = 0; i < k; i++) begin
                @(negedge clock);
                if (noise) iniciar = 1'($urandom_range(0, 1));
            end
            iniciar = 1'b0;
            chk("espera_before_play", 32'(estado_espera), 1);
            tem_jogada   = 1'b1;
            jogada_igual = igual;
            @(negedge clock);
            tem_jogada = 1'b0;
            chk("registra_estado", 32'(db_estado), C_REGISTRA);
            chk("registraR", 32'(registraR), 1);
            @(negedge clock);
            chk("compara_estado", 32'(db_estado), C_COMPARA);
            @(negedge clock);
            if (!igual) begin
                m_vidas--;
                m_to = 1'b0;
                chk("wrong_estado", 32'(db_estado), C_PERDE_VIDA);
            end else if (m_e < m_s) begin
                chk("next_play_estado", 32'(db_estado), C_PROX_JOGADA);
                m_e++;
                @(negedge clock);
                chk("next_play_espera", 32'(estado_espera), 1);
                chk("next_play_endereco", 32'(endereco), m_e);
                return;
            end else if (m_s == m_last) begin
                chk("win_estado", 32'(db_estado), C_FIM_ACERTO);
                chk("win_flags", 32'({acertou, pronto, errou}), 32'b110);
                chk("win_sequencia", 32'(sequencia), m_s);
                m_phase = 2;
                return;
            end else begin
                chk("next_seq_estado", 32'(db_estado), C_PROX_SEQ);
                m_s++;
                m_e     = 0;
                m_phase = 0;
                return;
            end
        end
        chk("lost_vidas", 32'(vidas), m_vidas);
        chk("lost_timeout_flag", 32'(errou_timeout), 32'(m_to));
        chk("lost_sequencia", 32'(sequencia), m_s);
        if (m_vidas == 0) begin
            @(negedge clock);
            chk("lose_estado", 32'(db_estado), C_FIM_ERRO);
            chk("lose_flags", 32'({errou, pronto, acertou}), 32'b110);
            chk("lose_vidas", 32'(vidas), 0);
            m_phase = 2;
        end else begin
            m_e     = 0;
            m_phase = 0;
        end
    endtask

    // err_mode 0: always correct; 1: random wrong plays, timeouts and idle time.
    task automatic run_game(input bit lvl, input int err_mode);
        int steps = 0;
        int r;
        start_game(lvl);
        while (m_phase != 2 && steps < 100) begin
            steps++;
            if (m_phase == 0) begin
                wait_show(m_s + 1);
            end else if (err_mode == 0) begin
                do_play(int'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b1);
            end else begin
                r = int'($urandom_range(0, 9));
                if (r == 0)      do_play(0, 1'b0, 1'b1, 1'b1);
                else if (r <= 2) do_play(int'($urandom_range(0, TO - 1)), 1'b0, 1'b0, 1'b1);
                else             do_play(int'($urandom_range(0, TO - 1)), 1'b1, 1'b0, 1'b1);
            end
        end
        chk("game_over_pronto", 32'(pronto), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        iniciar      = 1'b0;
        nivel        = 1'b0;
        tem_jogada   = 1'b0;
        jogada_igual = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk_reset_state("por");
        reset_n = 1'b1;
        @(negedge clock);
        chk("idle_holds", 32'(db_estado), C_INICIAL);

        // Short game, all plays correct
        run_game(1'b0, 0);
        chk("short_win_seq", 32'(sequencia), 1);
        @(negedge clock);
        @(negedge clock);
        chk("fim_acerto_holds", 32'(db_estado), C_FIM_ACERTO);

        // Full game, all plays correct
        run_game(1'b1, 0);
        chk("full_win_seq", 32'(sequencia), 3);

        // Wrong plays in round S=1: replay, then game over
        start_game(1'b1);
        wait_show(1);
        do_play(1, 1'b1, 1'b0, 1'b0);
        wait_show(2);
        do_play(0, 1'b1, 1'b0, 1'b0);
        do_play(2, 1'b0, 1'b0, 1'b0);
        wait_show(2);
        do_play(0, 1'b1, 1'b0, 1'b0);
        do_play(0, 1'b0, 1'b0, 1'b0);

        // Timeout, and a play on the very last allowed cycle
        start_game(1'b0);
        wait_show(1);
        do_play(0, 1'b0, 1'b1, 1'b0);
        wait_show(1);
        do_play(TO - 1, 1'b1, 1'b0, 1'b0);
        chk("last_cycle_no_life_lost", 32'(vidas), 1);
        wait_show(2);
        do_play(0, 1'b0, 1'b1, 1'b0);
        chk("timeout_game_over_flag", 32'(errou_timeout), 1);

        // Restart from FIM_ERRO, then random games
        run_game(1'b1, 1);
        for (int g = 0; g < 6; g++) begin
            run_game(1'($urandom_range(0, 1)), 1);
        end

        // Reset in the middle of ESPERA with non-trivial state
        start_game(1'b1);
        wait_show(1);
        do_play(0, 1'b1, 1'b0, 1'b0);
        wait_show(2);
        do_play(0, 1'b0, 1'b1, 1'b0);
        wait_show(2);
        do_play(0, 1'b1, 1'b0, 1'b0);
        reset_n = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk_reset_state("mid_reset");
        reset_n = 1'b1;
        @(negedge clock);
        chk("after_reset_idle", 32'(db_estado), C_INICIAL);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
